// File: rtl/lsq_data_drain_pkg.sv
// rtl/lsq_data_drain_pkg.sv - shared constants, output entry type and bit helpers for the LSQ data drain
package lsq_data_drain_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int DATA_WIDTH  = 64;
  localparam int IDX_WIDTH   = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_WIDTH-1:0]  idx;
  } deqEntry_t;

  function automatic logic [NUM_ENTRIES-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_ENTRIES-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [IDX_WIDTH:0] popcount(input logic [NUM_ENTRIES-1:0] vec);
    logic [IDX_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      n = n + {{IDX_WIDTH{1'b0}}, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lsq_drain_out_reg.sv
// rtl/lsq_drain_out_reg.sv - single-entry valid/ready output register that holds data while stalled
module lsq_drain_out_reg
  import lsq_data_drain_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic [IDX_WIDTH-1:0]  loadIdx,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [IDX_WIDTH-1:0]  idx
);

  deqEntry_t held;

  // A load only happens when the slot is empty or draining this cycle, so it may overwrite.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      held  <= '{data: loadData, idx: loadIdx};
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign data = held.data;
  assign idx  = held.idx;

endmodule

// File: rtl/lsq_data_drain.sv
// rtl/lsq_data_drain.sv - in-order circular reader of a one-hot addressed async-read data array
module lsq_data_drain
  import lsq_data_drain_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_alloc_valid,
  input  logic [NUM_ENTRIES-1:0] io_alloc_vec,
  input  logic                   io_flush,
  output logic [NUM_ENTRIES-1:0] io_rvec,
  input  logic [DATA_WIDTH-1:0]  io_rdata,
  output logic                   io_deq_valid,
  input  logic                   io_deq_ready,
  output logic [DATA_WIDTH-1:0]  io_deq_data,
  output logic [IDX_WIDTH-1:0]   io_deq_idx,
  output logic [IDX_WIDTH:0]     io_count,
  output logic                   io_alloc_conflict
);

  logic [NUM_ENTRIES-1:0] validBits;
  logic [NUM_ENTRIES-1:0] validNext;
  logic [NUM_ENTRIES-1:0] allocBits;
  logic [NUM_ENTRIES-1:0] conflictBits;
  logic [IDX_WIDTH-1:0]   deqPtr;
  logic [IDX_WIDTH:0]     countReg;
  logic                   conflictReg;
  logic                   fire;

  always_comb begin
    fire         = validBits[deqPtr] & (~io_deq_valid | io_deq_ready) & ~io_flush;
    io_rvec      = fire ? onehot(deqPtr) : '0;
    allocBits    = io_alloc_valid ? io_alloc_vec : '0;
    // An entry being read is still valid, but it is listed for clarity of the rule.
    conflictBits = allocBits & (validBits | io_rvec);
    validNext    = io_flush ? '0
                            : (validBits & ~io_rvec) | (allocBits & ~conflictBits);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validBits   <= '0;
      deqPtr      <= '0;
      countReg    <= '0;
      conflictReg <= 1'b0;
    end else begin
      validBits   <= validNext;
      countReg    <= popcount(validNext);
      conflictReg <= ~io_flush & (|conflictBits);
      if (io_flush) begin
        deqPtr <= '0;
      end else if (fire) begin
        deqPtr <= deqPtr + IDX_WIDTH'(1);
      end
    end
  end

  lsq_drain_out_reg outReg (
    .clock    (clock),
    .reset    (reset),
    .flush    (io_flush),
    .load     (fire),
    .loadData (io_rdata),
    .loadIdx  (deqPtr),
    .ready    (io_deq_ready),
    .valid    (io_deq_valid),
    .data     (io_deq_data),
    .idx      (io_deq_idx)
  );

  assign io_count          = countReg;
  assign io_alloc_conflict = conflictReg;

endmodule

// File: tb/tb_lsq_data_drain.sv
// tb/tb_lsq_data_drain.sv - directed bench with a behavioural drain model for lsq_data_drain
module tb_lsq_data_drain;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_alloc_valid;
  logic [15:0] io_alloc_vec;
  logic        io_flush;
  logic [15:0] io_rvec;
  logic [63:0] io_rdata;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [63:0] io_deq_data;
  logic [3:0]  io_deq_idx;
  logic [4:0]  io_count;
  logic        io_alloc_conflict;

  logic [63:0] mem [16];

  int nTests = 0;
  int nFail  = 0;

  lsq_data_drain dut (
    .clock             (clock),
    .reset             (reset),
    .io_alloc_valid    (io_alloc_valid),
    .io_alloc_vec      (io_alloc_vec),
    .io_flush          (io_flush),
    .io_rvec           (io_rvec),
    .io_rdata          (io_rdata),
    .io_deq_valid      (io_deq_valid),
    .io_deq_ready      (io_deq_ready),
    .io_deq_data       (io_deq_data),
    .io_deq_idx        (io_deq_idx),
    .io_count          (io_count),
    .io_alloc_conflict (io_alloc_conflict)
  );

  always #5 clock = ~clock;

  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      if (io_rvec[i]) io_rdata = io_rdata | mem[i];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Behavioural model: a set of pending entries, a read cursor and a one-slot output.
  bit [15:0]   mv;
  bit [15:0]   nv;
  int          mp;
  int          moi;
  int          mcnt;
  bit          mov;
  bit          mconf;
  bit          mFire;
  bit          c;
  logic [63:0] mod;
  logic [15:0] expRvec;

  always @(negedge clock) begin
    if (reset) begin
      mv = '0; mp = 0; mov = 0; mconf = 0; mcnt = 0; mod = '0; moi = 0;
      check("m_rst_rvec", 64'(io_rvec), 64'd0);
      check("m_rst_deq_valid", 64'(io_deq_valid), 64'd0);
    end else begin
      mFire   = mv[mp] && (!mov || io_deq_ready) && !io_flush;
      expRvec = mFire ? (16'd1 << mp) : 16'd0;
      check("m_rvec", 64'(io_rvec), 64'(expRvec));
      check("m_deq_valid", 64'(io_deq_valid), 64'(mov));
      if (mov) begin
        check("m_deq_data", io_deq_data, mod);
        check("m_deq_idx", 64'(io_deq_idx), 64'(moi));
      end
      check("m_count", 64'(io_count), 64'(mcnt));
      check("m_conflict", 64'(io_alloc_conflict), 64'(mconf));
      if (io_flush) begin
        mv = '0; mp = 0; mov = 0; mconf = 0;
      end else begin
        nv = mv;
        c  = 0;
        if (io_alloc_valid) begin
          for (int i = 0; i < 16; i++) begin
            if (io_alloc_vec[i]) begin
              if (mv[i] || (mFire && i == mp)) c = 1;
              else nv[i] = 1'b1;
            end
          end
        end
        if (mFire) begin
          nv[mp] = 1'b0;
          mod    = mem[mp];
          moi    = mp;
          mov    = 1;
          mp     = (mp + 1) % 16;
        end else if (mov && io_deq_ready) begin
          mov = 0;
        end
        mv    = nv;
        mconf = c;
      end
      mcnt = 0;
      for (int i = 0; i < 16; i++) mcnt += int'(mv[i]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic doFlush();
    io_flush = 1'b1;
    cyc();
    io_flush = 1'b0;
  endtask

  task automatic alloc(input logic [15:0] vec);
    io_alloc_valid = 1'b1;
    io_alloc_vec   = vec;
    cyc();
    io_alloc_valid = 1'b0;
    io_alloc_vec   = '0;
  endtask

  initial begin
    reset = 1'b1;
    io_alloc_valid = 1'b0;
    io_alloc_vec = '0;
    io_flush = 1'b0;
    io_deq_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 64'hA0 + 64'(i);
    cyc();
    check("rst_rvec", 64'(io_rvec), 64'd0);
    check("rst_deq_valid", 64'(io_deq_valid), 64'd0);
    check("rst_deq_data", io_deq_data, 64'd0);
    check("rst_deq_idx", 64'(io_deq_idx), 64'd0);
    check("rst_count", 64'(io_count), 64'd0);
    check("rst_conflict", 64'(io_alloc_conflict), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Basic drain of three entries at full throughput
    alloc(16'h0007);
    #1;
    check("s1_rvec0", 64'(io_rvec), 64'h1);
    check("s1_count3", 64'(io_count), 64'd3);
    cyc();
    check("s1_data0", io_deq_data, 64'hA0);
    check("s1_rvec1", 64'(io_rvec), 64'h2);
    check("s1_count2", 64'(io_count), 64'd2);
    cyc();
    check("s1_data1", io_deq_data, 64'hA1);
    check("s1_idx1", 64'(io_deq_idx), 64'd1);
    check("s1_rvec2", 64'(io_rvec), 64'h4);
    check("s1_count1", 64'(io_count), 64'd1);
    cyc();
    check("s1_data2", io_deq_data, 64'hA2);
    check("s1_idx2", 64'(io_deq_idx), 64'd2);
    check("s1_count0", 64'(io_count), 64'd0);
    cyc();
    check("s1_idle", 64'(io_deq_valid), 64'd0);

    // Back-pressure holds the output stable
    doFlush();
    mem[0] = 64'hB0; mem[1] = 64'hB1;
    io_deq_ready = 1'b0;
    alloc(16'h0003);
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("s2_hold_valid", 64'(io_deq_valid), 64'd1);
      check("s2_hold_idx", 64'(io_deq_idx), 64'd0);
      check("s2_hold_data", io_deq_data, 64'hB0);
      check("s2_hold_rvec", 64'(io_rvec), 64'd0);
      check("s2_hold_count", 64'(io_count), 64'd1);
      cyc();
    end
    io_deq_ready = 1'b1;
    #1;
    check("s2_release_rvec", 64'(io_rvec), 64'h2);
    cyc();
    check("s2_idx1", 64'(io_deq_idx), 64'd1);
    check("s2_data1", io_deq_data, 64'hB1);
    cyc();

    // A hole at the pointer stalls the drain
    doFlush();
    mem[0] = 64'hD0; mem[1] = 64'hD1;
    alloc(16'h0002);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("s3_stall_rvec", 64'(io_rvec), 64'd0);
      check("s3_stall_valid", 64'(io_deq_valid), 64'd0);
      cyc();
    end
    alloc(16'h0001);
    cyc();
    check("s3_idx0", 64'(io_deq_idx), 64'd0);
    cyc();
    check("s3_idx1", 64'(io_deq_idx), 64'd1);
    check("s3_data1", io_deq_data, 64'hD1);
    cyc();

    // Pointer wrap 15 -> 0
    doFlush();
    alloc(16'h7FFF);
    repeat (18) cyc();
    mem[15] = 64'hEF; mem[0] = 64'hE0;
    alloc(16'h8001);
    #1;
    check("s4_rvec15", 64'(io_rvec), 64'h8000);
    cyc();
    check("s4_idx15", 64'(io_deq_idx), 64'd15);
    check("s4_data15", io_deq_data, 64'hEF);
    check("s4_rvec0", 64'(io_rvec), 64'h1);
    cyc();
    check("s4_idx0", 64'(io_deq_idx), 64'd0);
    check("s4_data0", io_deq_data, 64'hE0);
    alloc(16'h0002);
    #1;
    check("s4_ptr1", 64'(io_rvec), 64'h2);
    cyc(); cyc();

    // Conflicting allocation during the fire of entry 0
    doFlush();
    io_alloc_valid = 1'b1; io_alloc_vec = 16'h0001;
    cyc();
    io_alloc_vec = 16'h0003;
    #1;
    check("s5_fire_rvec", 64'(io_rvec), 64'h1);
    cyc();
    io_alloc_valid = 1'b0; io_alloc_vec = '0;
    #1;
    check("s5_conflict", 64'(io_alloc_conflict), 64'd1);
    check("s5_count", 64'(io_count), 64'd1);
    check("s5_rvec1", 64'(io_rvec), 64'h2);
    cyc();
    check("s5_conflict_clear", 64'(io_alloc_conflict), 64'd0);
    check("s5_idx1", 64'(io_deq_idx), 64'd1);
    cyc();

    // Flush beats alloc, then reset mid-stream
    doFlush();
    for (int i = 0; i < 16; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    alloc(16'hFFFF);
    #1;
    check("s6_count16", 64'(io_count), 64'd16);
    cyc(); cyc();
    check("s6_count14", 64'(io_count), 64'd14);
    io_flush = 1'b1; io_alloc_valid = 1'b1; io_alloc_vec = 16'h0010;
    #1;
    check("s6_flush_rvec", 64'(io_rvec), 64'd0);
    cyc();
    io_flush = 1'b0; io_alloc_valid = 1'b0; io_alloc_vec = '0;
    #1;
    check("s6_count0", 64'(io_count), 64'd0);
    check("s6_valid0", 64'(io_deq_valid), 64'd0);
    check("s6_rvec0", 64'(io_rvec), 64'd0);
    alloc(16'h0003);
    #1;
    check("s6_ptr0", 64'(io_rvec), 64'h1);
    cyc();
    check("s6_pre_rst_valid", 64'(io_deq_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("s6_rst_rvec", 64'(io_rvec), 64'd0);
    check("s6_rst_valid", 64'(io_deq_valid), 64'd0);
    check("s6_rst_data", io_deq_data, 64'd0);
    check("s6_rst_idx", 64'(io_deq_idx), 64'd0);
    check("s6_rst_count", 64'(io_count), 64'd0);
    check("s6_rst_conflict", 64'(io_alloc_conflict), 64'd0);
    cyc();
    reset = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
